// File: rtl/halfband_mac_scheduler.sv
// -----------------------------------------------------------------------------
// halfband_mac_scheduler
//
// Control and data-staging block for a 2:1 halfband decimator that shares one
// external multiply-accumulator. Samples arrive in pairs. The even sample of
// each pair feeds the phase-0 tap history. The odd sample feeds the centre-tap
// delay line. Once a pair is complete, the block issues NUM_TAPS+1 product
// terms to the MAC. It then rounds and saturates the accumulated result and
// presents it on a backpressured output.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   valid_in     input sample valid
//   data_in      signed input sample
//   in_ready     sample accepted this cycle (IDLE only)
//   valid_out    decimated output valid
//   data_out     signed decimated output, held until out_ready
//   out_ready    downstream accepts the output
//   cfg_we       coefficient write strobe
//   cfg_addr     0..NUM_TAPS-1 = phase-0 coefficients, NUM_TAPS = centre
//   cfg_data     coefficient value (Q1.15)
//   cfg_ready    coefficient writes accepted (IDLE only)
//   mac_start    a product term is presented
//   mac_first    clear the accumulator before this term
//   mac_last     final term of this output
//   mac_a        sample operand
//   mac_b        coefficient operand
//   mac_ready    MAC accepts the presented term
//   mac_valid    one-cycle pulse: accumulation complete
//   mac_result   signed accumulated sum
// -----------------------------------------------------------------------------
module halfband_mac_scheduler #(
    parameter int SAMPLE_WIDTH = 6,
    parameter int COEF_WIDTH   = 16,
    parameter int NUM_TAPS     = 8,
    parameter int CENTER_DELAY = NUM_TAPS / 2,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_SHIFT    = 15,
    localparam int ADDR_WIDTH  = $clog2(NUM_TAPS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    output logic                    in_ready,
    output logic                    valid_out,
    output logic [SAMPLE_WIDTH-1:0] data_out,
    input  logic                    out_ready,
    input  logic                    cfg_we,
    input  logic [ADDR_WIDTH-1:0]   cfg_addr,
    input  logic [COEF_WIDTH-1:0]   cfg_data,
    output logic                    cfg_ready,
    output logic                    mac_start,
    output logic                    mac_first,
    output logic                    mac_last,
    output logic [SAMPLE_WIDTH-1:0] mac_a,
    output logic [COEF_WIDTH-1:0]   mac_b,
    input  logic                    mac_ready,
    input  logic                    mac_valid,
    input  logic [ACC_WIDTH-1:0]    mac_result
);

    localparam int TAP_IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_TERM = ADDR_WIDTH'(NUM_TAPS);

    // Rounding offset and saturation bounds, all at ACC_WIDTH+1 bits so the
    // rounding add can never wrap.
    localparam logic signed [ACC_WIDTH:0] ROUND_C =
        (ACC_WIDTH + 1)'(1'b1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        ((ACC_WIDTH + 1)'(1'b1) << (SAMPLE_WIDTH - 1)) - (ACC_WIDTH + 1)'(1'b1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    // Round half-up with an arithmetic shift, then clamp into the sample range.
    function automatic logic [SAMPLE_WIDTH-1:0] round_sat(input logic [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH:0] wide;
        logic signed [ACC_WIDTH:0] shifted;
        logic [SAMPLE_WIDTH-1:0]   res;
        wide    = $signed({acc[ACC_WIDTH-1], acc}) + ROUND_C;
        shifted = wide >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[SAMPLE_WIDTH-1:0];
        end else begin
            res = shifted[SAMPLE_WIDTH-1:0];
        end
        return res;
    endfunction

    // State registers
    state_t                  state_q,    state_d;
    logic                    phase_q,    phase_d;
    logic [ADDR_WIDTH-1:0]   term_q,     term_d;
    logic [SAMPLE_WIDTH-1:0] hist_q     [NUM_TAPS];
    logic [SAMPLE_WIDTH-1:0] hist_d     [NUM_TAPS];
    logic [SAMPLE_WIDTH-1:0] ctr_q      [CENTER_DELAY+1];
    logic [SAMPLE_WIDTH-1:0] ctr_d      [CENTER_DELAY+1];
    logic [COEF_WIDTH-1:0]   coef_q     [NUM_TAPS];
    logic [COEF_WIDTH-1:0]   coef_d     [NUM_TAPS];
    logic [COEF_WIDTH-1:0]   coef_ctr_q, coef_ctr_d;

    // Registered outputs
    logic                    in_ready_q,  in_ready_d;
    logic                    cfg_ready_q, cfg_ready_d;
    logic                    valid_out_q, valid_out_d;
    logic [SAMPLE_WIDTH-1:0] data_out_q,  data_out_d;
    logic                    mac_start_q, mac_start_d;
    logic                    mac_first_q, mac_first_d;
    logic                    mac_last_q,  mac_last_d;
    logic [SAMPLE_WIDTH-1:0] mac_a_q,     mac_a_d;
    logic [COEF_WIDTH-1:0]   mac_b_q,     mac_b_d;

    logic in_xfer_s;
    logic cfg_xfer_s;
    logic mac_xfer_s;

    assign in_xfer_s  = valid_in && in_ready_q;
    assign cfg_xfer_s = cfg_we && cfg_ready_q;
    assign mac_xfer_s = mac_start_q && mac_ready;

    // Next-state logic: sample staging, config writes, term sequencing, output.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        term_d      = term_q;
        hist_d      = hist_q;
        ctr_d       = ctr_q;
        coef_d      = coef_q;
        coef_ctr_d  = coef_ctr_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;

        case (state_q)
            ST_IDLE: begin
                if (in_xfer_s) begin
                    if (!phase_q) begin
                        for (int k = NUM_TAPS - 1; k > 0; k--) begin
                            hist_d[k] = hist_q[k-1];
                        end
                        hist_d[0] = data_in;
                    end else begin
                        for (int k = CENTER_DELAY; k > 0; k--) begin
                            ctr_d[k] = ctr_q[k-1];
                        end
                        ctr_d[0] = data_in;
                        // The pair is complete, so start issuing terms.
                        state_d  = ST_ISSUE;
                        term_d   = '0;
                    end
                    phase_d = ~phase_q;
                end else begin
                    phase_d = phase_q;
                end

                // An out-of-range address is dropped rather than aliased.
                if (cfg_xfer_s) begin
                    if (cfg_addr < LAST_TERM) begin
                        coef_d[cfg_addr[TAP_IDX_W-1:0]] = cfg_data;
                    end else if (cfg_addr == LAST_TERM) begin
                        coef_ctr_d = cfg_data;
                    end else begin
                        coef_ctr_d = coef_ctr_q;
                    end
                end else begin
                    coef_ctr_d = coef_ctr_q;
                end
            end

            ST_ISSUE: begin
                if (mac_xfer_s) begin
                    if (term_q == LAST_TERM) begin
                        state_d = ST_WAIT;
                        term_d  = '0;
                    end else begin
                        term_d  = term_q + ADDR_WIDTH'(1'b1);
                    end
                end else begin
                    term_d = term_q;
                end
            end

            ST_WAIT: begin
                if (mac_valid) begin
                    data_out_d  = round_sat(mac_result);
                    valid_out_d = 1'b1;
                    state_d     = ST_OUTPUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_OUTPUT: begin
                if (out_ready) begin
                    valid_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    valid_out_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next-state. MAC operands come from next-state storage, so a term
    // is valid in the first ISSUE cycle even with a zero centre delay.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        cfg_ready_d = (state_d == ST_IDLE);
        mac_start_d = (state_d == ST_ISSUE);
        mac_first_d = 1'b0;
        mac_last_d  = 1'b0;
        mac_a_d     = '0;
        mac_b_d     = '0;
        if (mac_start_d) begin
            mac_first_d = (term_d == '0);
            if (term_d < LAST_TERM) begin
                mac_a_d = hist_d[term_d[TAP_IDX_W-1:0]];
                mac_b_d = coef_d[term_d[TAP_IDX_W-1:0]];
            end else begin
                mac_a_d    = ctr_d[CENTER_DELAY];
                mac_b_d    = coef_ctr_d;
                mac_last_d = 1'b1;
            end
        end else begin
            mac_first_d = 1'b0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            term_q      <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                hist_q[k] <= '0;
                coef_q[k] <= '0;
            end
            for (int k = 0; k <= CENTER_DELAY; k++) begin
                ctr_q[k] <= '0;
            end
            coef_ctr_q  <= '0;
            in_ready_q  <= 1'b1;
            cfg_ready_q <= 1'b1;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            mac_start_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            term_q      <= term_d;
            hist_q      <= hist_d;
            ctr_q       <= ctr_d;
            coef_q      <= coef_d;
            coef_ctr_q  <= coef_ctr_d;
            in_ready_q  <= in_ready_d;
            cfg_ready_q <= cfg_ready_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            mac_start_q <= mac_start_d;
            mac_first_q <= mac_first_d;
            mac_last_q  <= mac_last_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign cfg_ready = cfg_ready_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign mac_start = mac_start_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;

endmodule

// File: tb/tb_halfband_mac_scheduler.sv
module tb_halfband_mac_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic               valid_in;
    logic signed [5:0]  data_in;
    logic               in_ready;
    logic               valid_out;
    logic signed [5:0]  data_out;
    logic               out_ready;
    logic               cfg_we;
    logic [3:0]         cfg_addr;
    logic [15:0]        cfg_data;
    logic               cfg_ready;
    logic               mac_start;
    logic               mac_first;
    logic               mac_last;
    logic signed [5:0]  mac_a;
    logic signed [15:0] mac_b;
    logic               mac_ready;
    logic               mac_valid = 1'b0;
    logic signed [31:0] mac_result = 32'sd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    halfband_mac_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .in_ready   (in_ready),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .out_ready  (out_ready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .mac_start  (mac_start),
        .mac_first  (mac_first),
        .mac_last   (mac_last),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_ready  (mac_ready),
        .mac_valid  (mac_valid),
        .mac_result (mac_result)
    );

    // ---------------- behavioural MAC ----------------
    int                 term_cnt = 0;
    logic [15:0]        fmask = 16'h0000;
    logic [15:0]        lmask = 16'h0000;
    int                 done_cnt = 0;
    logic [15:0]        done_fm = 16'h0000;
    logic [15:0]        done_lm = 16'h0000;
    logic signed [31:0] acc = 32'sd0;

    int                 idx_s;
    logic signed [31:0] prod_s;
    logic signed [31:0] accn_s;
    logic [15:0]        bit_s;
    logic [15:0]        fm_n_s;
    logic [15:0]        lm_n_s;

    assign idx_s  = mac_first ? 0 : term_cnt;
    assign prod_s = mac_a * mac_b;
    assign accn_s = mac_first ? prod_s : acc + prod_s;
    assign bit_s  = (idx_s < 16) ? (16'h0001 << idx_s) : 16'h0000;
    assign fm_n_s = mac_first ? bit_s : fmask;
    assign lm_n_s = (mac_first ? 16'h0000 : lmask) | (mac_last ? bit_s : 16'h0000);

    always @(posedge clk) begin
        mac_valid <= 1'b0;
        if (mac_start && mac_ready) begin
            acc      <= accn_s;
            term_cnt <= idx_s + 1;
            fmask    <= fm_n_s;
            lmask    <= lm_n_s;
            if (mac_last) begin
                mac_valid  <= 1'b1;
                mac_result <= accn_s;
                done_cnt   <= idx_s + 1;
                done_fm    <= fm_n_s;
                done_lm    <= lm_n_s;
            end
        end
    end

    // Output collector: one entry per completed output handshake.
    logic signed [5:0] outq[$];
    always @(posedge clk) begin
        if (reset && valid_out && out_ready) outq.push_back(data_out);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        outq.delete();
        @(negedge clk);
    endtask

    task automatic write_cfg(input logic [3:0] a, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        while (!cfg_ready && n < 200) begin @(negedge clk); n++; end
        if (!cfg_ready) check("cfg_ready_timeout", 0, 1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic apply_cfg(input logic [2:0] code);
        for (int k = 0; k <= 8; k++) begin
            logic [15:0] d;
            case (code)
                3'd1:    d = (k < 8) ? 16'(2048 * (k + 1)) : 16'd0;
                3'd2:    d = (k == 8) ? 16'd16384 : 16'd0;
                default: d = 16'd32767;
            endcase
            write_cfg(4'(k), d);
        end
    endtask

    task automatic send_sample(input logic signed [5:0] x);
        int n;
        n = 0;
        @(negedge clk);
        valid_in = 1'b1; data_in = x;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic get_out(input string name, input int exp);
        int n;
        logic signed [5:0] v;
        n = 0;
        while (outq.size() == 0 && n < 400) begin @(negedge clk); n++; end
        if (outq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: no output within budget, expected %0d", name, exp);
        end else begin
            v = outq.pop_front();
            check(name, int'(v), exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]        cfg;   // 0: keep, else reset + load coefficient set
        logic signed [5:0] ev;
        logic signed [5:0] od;
        logic signed [5:0] exp;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs[NV];

    initial begin
        int n;
        int found;

        // Phase-0 impulse: outputs 1..8 then 0.
        for (int i = 0; i < 12; i++) begin
            vecs[i].cfg = (i == 0) ? 3'd1 : 3'd0;
            vecs[i].ev  = (i == 0) ? 6'sd16 : 6'sd0;
            vecs[i].od  = 6'sd0;
            vecs[i].exp = (i < 8) ? 6'(i + 1) : 6'sd0;
        end
        // Centre impulse: only output 4 is 8.
        for (int i = 0; i < 8; i++) begin
            vecs[12+i].cfg = (i == 0) ? 3'd2 : 3'd0;
            vecs[12+i].ev  = 6'sd0;
            vecs[12+i].od  = (i == 0) ? 6'sd16 : 6'sd0;
            vecs[12+i].exp = (i == 4) ? 6'sd8 : 6'sd0;
        end
        // Saturation, positive then negative.
        for (int i = 0; i < 6; i++) begin
            vecs[20+i].cfg = (i == 0) ? 3'd3 : 3'd0;
            vecs[20+i].ev  = 6'sd31;
            vecs[20+i].od  = 6'sd31;
            vecs[20+i].exp = 6'sd31;
            vecs[26+i].cfg = (i == 0) ? 3'd3 : 3'd0;
            vecs[26+i].ev  = -6'sd32;
            vecs[26+i].od  = -6'sd32;
            vecs[26+i].exp = -6'sd32;
        end

        // ---- reset held with activity on the inputs ----
        reset = 1'b0; valid_in = 1'b1; data_in = 6'sd5;
        cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 16'd1234;
        out_ready = 1'b1; mac_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cfg_we = ~cfg_we;
            check("rst_valid_out", int'(valid_out), 0);
            check("rst_data_out", int'(data_out), 0);
            check("rst_mac_start", int'(mac_start), 0);
        end
        @(negedge clk);
        reset = 1'b1; valid_in = 1'b0; cfg_we = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready", int'(in_ready), 1);
        check("rel_cfg_ready", int'(cfg_ready), 1);
        check("rel_mac_start", int'(mac_start), 0);
        // Coefficients stayed zero through reset, so the first output is 0.
        send_sample(6'sd16); send_sample(6'sd0);
        get_out("post_reset_zero", 0);

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].cfg != 3'd0) begin
                do_reset();
                apply_cfg(vecs[i].cfg);
            end
            send_sample(vecs[i].ev);
            send_sample(vecs[i].od);
            get_out($sformatf("vec%0d_out", i), int'(vecs[i].exp));
            check($sformatf("vec%0d_terms", i), done_cnt, 9);
            check($sformatf("vec%0d_first", i), int'(done_fm), 1);
            check($sformatf("vec%0d_last", i), int'(done_lm), 256);
        end

        // ---- MAC stall on term 5 ----
        do_reset();
        apply_cfg(3'd1);
        send_sample(6'sd16); send_sample(6'sd0);
        get_out("stall_pre0", 1);
        for (int i = 1; i < 5; i++) begin
            send_sample(6'sd0); send_sample(6'sd0);
            get_out($sformatf("stall_pre%0d", i), i + 1);
        end
        send_sample(6'sd0); send_sample(6'sd0);
        check("lat_mac_start", int'(mac_start), 1);
        check("lat_mac_first", int'(mac_first), 1);
        n = 0; found = 0;
        @(negedge clk);
        while (!(mac_start && term_cnt == 5) && n < 50) begin @(negedge clk); n++; end
        if (mac_start && term_cnt == 5) found = 1;
        check("stall_reach_t5", found, 1);
        mac_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("stall_mac_start", int'(mac_start), 1);
            check("stall_mac_a", int'(mac_a), 16);
            check("stall_mac_b", int'(mac_b), 12288);
            check("stall_term_held", term_cnt, 5);
        end
        mac_ready = 1'b1;
        get_out("stall_out", 6);
        check("stall_terms", done_cnt, 9);

        // ---- output backpressure ----
        out_ready = 1'b0;
        send_sample(6'sd0); send_sample(6'sd0);
        n = 0;
        @(negedge clk);
        while (!valid_out && n < 100) begin @(negedge clk); n++; end
        check("bp_valid_seen", int'(valid_out), 1);
        valid_in = 1'b1; data_in = 6'sd9;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_out", int'(valid_out), 1);
            check("bp_data_out", int'(data_out), 7);
            check("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        valid_in = 1'b0; out_ready = 1'b1;
        get_out("bp_out", 7);
        @(negedge clk);
        check("bp_valid_drop", int'(valid_out), 0);
        send_sample(6'sd0); send_sample(6'sd0);
        get_out("bp_history_intact", 8);

        // ---- config write while busy, out-of-range write ----
        do_reset();
        write_cfg(4'd0, 16'd2048);
        send_sample(6'sd16); send_sample(6'sd0);
        check("busy_cfg_ready", int'(cfg_ready), 0);
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 16'd30000;
        @(posedge clk); @(posedge clk); #1;
        cfg_we = 1'b0;
        get_out("busy_cfg_out0", 1);
        send_sample(6'sd16); send_sample(6'sd0);
        get_out("busy_cfg_dropped", 1);
        write_cfg(4'd9, 16'h7FFF);
        send_sample(6'sd0); send_sample(6'sd0);
        get_out("oob_cfg_dropped", 0);

        // ---- reset in the middle of ISSUE ----
        send_sample(6'sd16); send_sample(6'sd0);
        n = 0; found = 0;
        @(negedge clk);
        while (!(mac_start && term_cnt == 3) && n < 50) begin @(negedge clk); n++; end
        if (mac_start && term_cnt == 3) found = 1;
        check("midrst_reach_t3", found, 1);
        reset = 1'b0;
        #1;
        check("midrst_mac_start", int'(mac_start), 0);
        check("midrst_valid_out", int'(valid_out), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_output", outq.size(), 0);
        send_sample(6'sd5); send_sample(6'sd7);
        get_out("midrst_zeroed", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
